// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential shift-add multiplier.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   MULT_W    : operand width
//   MULT_ITER : number of add/shift iterations per product
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_W    = 16;
  localparam int MULT_ITER = 16;

endpackage

// File: rtl/cla_16b.sv
// cla_16b: 16-bit carry-lookahead adder built from four 4-bit lookahead
// groups joined by a second-level lookahead carry unit.
// Ports:
//   a, b   : 16-bit addends
//   c_in   : carry into bit 0
//   s      : 16-bit sum
//   c_out  : carry out of bit 15
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    // Group generate/propagate
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Second-level lookahead: carries into each group
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
    // Bit carries inside each group, all derived from the group carry-in
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign s     = p ^ c;
  assign c_out = gc[4];

endmodule

// File: rtl/mult_seq_16b.sv
// mult_seq_16b: sequential 16x16 unsigned shift-add multiplier sharing a
// single cla_16b. One conditional add plus one right shift per RUN cycle;
// a start/done handshake frames each 32-bit product.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset (aborts any operation)
//   start   : request, sampled only while busy=0
//   a, b    : multiplicand / multiplier, latched on an accepted start
//   product : 32-bit result, held from done until the next accepted start
//   done    : high for the single cycle the FSM sits in DONE
//   busy    : high exactly while in RUN
// Build option: define MULT_EARLY_TERM_EN to finish early once the
// remaining multiplier bits are all zero (product is unchanged).
module mult_seq_16b
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  state_t             state;
  logic [WIDTH-1:0]   m_r, a_r, q_r;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] product_r;

  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] aq_nxt;
  logic [4:0]         cnt_inc;
  logic               finish;

  cla_16b u_cla (
    .a     (a_r),
    .b     (m_r),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (carry)
  );

  always_comb begin
    // Carry of the add lands in the MSB of A on the same shift
    aq_nxt  = q_r[0] ? {carry, sum, q_r[WIDTH-1:1]}
                     : {1'b0, a_r, q_r[WIDTH-1:1]};
    cnt_inc = cnt + 5'd1;
    finish  = (cnt_inc == 5'(MULT_ITER));
`ifdef MULT_EARLY_TERM_EN
    // Unconsumed multiplier bits live in Q[15-cnt:0]. Once they are zero,
    // one shift by (16-cnt) lands the product; written as a shift by
    // ~cnt (=15-cnt) then by 1 so no subtractor is needed.
    if ((q_r & (16'hFFFF >> cnt[3:0])) == '0) begin
      aq_nxt = ({a_r, q_r} >> (~cnt[3:0])) >> 1;
      finish = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      m_r       <= '0;
      a_r       <= '0;
      q_r       <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m_r   <= a;
            a_r   <= '0;
            q_r   <= b;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          {a_r, q_r} <= aq_nxt;
          cnt        <= cnt_inc;
          if (finish) begin
            product_r <= aq_nxt;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = product_r;

endmodule

// File: tb/tb_mult_seq_16b.sv
// tb_mult_seq_16b: directed-vector bench for mult_seq_16b. Stimulus pushes
// the expected product and done cycle into a queue; a monitor pops and
// compares every time done is seen.
module tb_mult_seq_16b;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [31:0] product;
  logic        done, busy;

  mult_seq_16b dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] prod;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Done cycle relative to the start cycle.
  function automatic int lat(logic [15:0] bv);
`ifdef MULT_EARLY_TERM_EN
    int m = -1;
    for (int i = 0; i < 16; i++) if (bv[i]) m = i;
    if (m < 0) return 2;
    return (m + 3 > 17) ? 17 : m + 3;
`else
    return 17;
`endif
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("product", product, e.prod);
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Call at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] p);
    exp_t e;
    e.prod = p;
    e.at   = cyc + lat(bv);
    sb.push_back(e);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int l;
    repeat (3) @(negedge clk);
    chk("reset_product", product, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 3*5 with busy profile
    l = lat(16'd5);
    issue(16'd3, 16'd5, 32'h0000000F);
    for (int k = 1; k <= 18; k++) begin
      chk("busy_profile", {31'b0, busy}, {31'b0, (k < l)});
      @(negedge clk);
    end
    wait_idle();

    // Max operands, then back-to-back start in the done cycle
    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    repeat (16) @(negedge clk);
    issue(16'h1234, 16'h0002, 32'h00002468);
    wait_idle();

    // Start during RUN (cycles 5..10) must be ignored
    issue(16'h00FF, 16'h8001, 32'h007F80FF);
    repeat (4) @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset at cycle 8 aborts the operation
    issue(16'h0007, 16'h8003, 32'h0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_product", product, 32'h0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_idle_busy", {31'b0, busy}, 32'h0);
    issue(16'd3, 16'd5, 32'h0000000F);
    wait_idle();

    // Sparse multipliers (early-exit cases when enabled)
    issue(16'hABCD, 16'h0000, 32'h00000000);
    wait_idle();
    issue(16'hABCD, 16'h0001, 32'h0000ABCD);
    wait_idle();
    issue(16'h0002, 16'h8000, 32'h00010000);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
